// File: rtl/dfe_apb_cfg_regs_pkg.sv
// Shared definitions for the DFE APB configuration bank: register map,
// CTRL field layout, commit FSM states and small helpers.
package dfe_apb_cfg_regs_pkg;

  localparam int unsigned ADDR_CTRL      = 32'd0;
  localparam int unsigned ADDR_COMMIT    = 32'd1;
  localparam int unsigned ADDR_COEF_BASE = 32'd2;
  localparam int unsigned ADDR_STATUS    = 32'd14;
  localparam int unsigned ADDR_ID        = 32'd15;

  localparam int CTRL_BLK_EN_LSB = 0;
  localparam int CTRL_BLK_EN_W   = 5;
  localparam int CTRL_CIC_LSB    = 9;
  localparam int CTRL_CIC_W      = 5;

  localparam logic [4:0]  CIC_LOG2_MAX  = 5'd4;
  localparam logic [31:0] ID_VALUE_DFLT = 32'hDFE0_0002;

  typedef enum logic [0:0] {
    CS_IDLE    = 1'b0,
    CS_PENDING = 1'b1
  } commit_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) r = v;
    else            r = v + 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/dfe_apb_cfg_regs_apb_slave_if.sv
// APB3 slave front end: phase decode, wait-state counter, PREADY generation
// and single-cycle write/read strobes aligned with the completing cycle.
module apb_slave_if
  import dfe_apb_cfg_regs_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pready,
  output logic                  wr_stb,
  output logic                  rd_stb,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [2:0] wait_cnt_r;
  logic       live_r;
  logic       access_s;

  assign access_s = psel & penable;
  // live_r keeps PREADY low while reset is (or has just been) asserted
  assign pready   = access_s & live_r & (wait_cnt_r == 3'(WAIT_STATES));
  assign wr_stb   = pready & pwrite;
  assign rd_stb   = pready & ~pwrite;
  assign addr     = paddr;

  // Marks the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_r <= 1'b0;
    else        live_r <= 1'b1;
  end

  // Counts stalled access cycles; an abandoned or completed transfer restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wait_cnt_r <= 3'd0;
    else if (!psel || pready)  wait_cnt_r <= 3'd0;
    else if (access_s)         wait_cnt_r <= wait_cnt_r + 3'd1;
    else                       wait_cnt_r <= wait_cnt_r;
  end

endmodule

// File: rtl/dfe_apb_cfg_regs.sv
// DFE configuration bank: APB-programmed shadow registers committed atomically
// to the active datapath configuration on a sample boundary.
module dfe_apb_cfg_regs
  import dfe_apb_cfg_regs_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 4,
  parameter int          DATA_WIDTH  = 32,
  parameter int          N_COEF_REGS = 5,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DFLT
) (
  input  logic                              PCLK,
  input  logic                              PRESETn,
  input  logic                              PSEL,
  input  logic                              PENABLE,
  input  logic                              PWRITE,
  input  logic [ADDR_WIDTH-1:0]             PADDR,
  input  logic [DATA_WIDTH-1:0]             PWDATA,
  output logic [DATA_WIDTH-1:0]             PRDATA,
  output logic                              PREADY,
  output logic                              PSLVERR,
  input  logic                              sample_tick,
  output logic [4:0]                        blk_en,
  output logic [4:0]                        cic_decim_log2,
  output logic [N_COEF_REGS*DATA_WIDTH-1:0] coef_bus,
  output logic                              commit_pending,
  output logic                              cfg_updated
);

  logic                                   pready_s, wr_stb_s, rd_stb_s;
  logic [ADDR_WIDTH-1:0]                  addr_s;
  logic [31:0]                            addr_u_s;
  logic                                   mapped_s, err_s, wr_en_s, commit_wr_s, apply_s;
  logic [N_COEF_REGS-1:0]                 coef_hit_s;
  logic [DATA_WIDTH-1:0]                  coef_rd_s, rdata_s;
  logic [CTRL_BLK_EN_W-1:0]               blk_en_sh_r, blk_en_act_r;
  logic [CTRL_CIC_W-1:0]                  cic_sh_r, cic_act_r;
  logic [N_COEF_REGS-1:0][DATA_WIDTH-1:0] coef_sh_r, coef_act_r;
  logic [7:0]                             err_cnt_r;
  logic                                   cfg_updated_r;
  commit_state_t                          state_r, state_nxt_s;

  apb_slave_if #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WAIT_STATES (WAIT_STATES)
  ) u_apb (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .psel    (PSEL),
    .penable (PENABLE),
    .pwrite  (PWRITE),
    .paddr   (PADDR),
    .pready  (pready_s),
    .wr_stb  (wr_stb_s),
    .rd_stb  (rd_stb_s),
    .addr    (addr_s)
  );

  assign addr_u_s = 32'(addr_s);

  // Coefficient window hit vector and shadow readback select
  always_comb begin
    coef_hit_s = '0;
    coef_rd_s  = '0;
    for (int k = 0; k < N_COEF_REGS; k++) begin
      coef_hit_s[k] = (addr_u_s == ADDR_COEF_BASE + 32'(k));
      coef_rd_s     = coef_rd_s | (coef_sh_r[k] & {DATA_WIDTH{coef_hit_s[k]}});
    end
  end

  // Address map check and PSLVERR conditions
  always_comb begin
    mapped_s = 1'b0;
    err_s    = 1'b0;
    case (addr_u_s)
      ADDR_CTRL, ADDR_COMMIT, ADDR_STATUS, ADDR_ID: mapped_s = 1'b1;
      default:                                      mapped_s = |coef_hit_s;
    endcase
    if (!mapped_s)
      err_s = 1'b1;
    else if (PWRITE && ((addr_u_s == ADDR_STATUS) || (addr_u_s == ADDR_ID)))
      err_s = 1'b1;
    else if (PWRITE && (addr_u_s == ADDR_CTRL) &&
             (PWDATA[CTRL_CIC_LSB +: CTRL_CIC_W] > CIC_LOG2_MAX))
      err_s = 1'b1;
    else
      err_s = 1'b0;
  end

  assign wr_en_s     = wr_stb_s & ~err_s;
  assign commit_wr_s = wr_en_s & (addr_u_s == ADDR_COMMIT) & PWDATA[0];

  // Shadow bank: written only by an error-free completing APB write
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      blk_en_sh_r <= '0;
      cic_sh_r    <= '0;
      coef_sh_r   <= '0;
    end else if (wr_en_s) begin
      if (addr_u_s == ADDR_CTRL) begin
        blk_en_sh_r <= PWDATA[CTRL_BLK_EN_LSB +: CTRL_BLK_EN_W];
        cic_sh_r    <= PWDATA[CTRL_CIC_LSB +: CTRL_CIC_W];
      end
      for (int k = 0; k < N_COEF_REGS; k++) begin
        if (coef_hit_s[k]) coef_sh_r[k] <= PWDATA;
      end
    end
  end

  // Commit FSM state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_r <= CS_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Commit FSM next state; a commit requested on a tick waits for the next tick
  always_comb begin
    state_nxt_s = state_r;
    apply_s     = 1'b0;
    case (state_r)
      CS_IDLE: begin
        if (commit_wr_s) state_nxt_s = CS_PENDING;
        else             state_nxt_s = CS_IDLE;
      end
      CS_PENDING: begin
        if (sample_tick) begin
          state_nxt_s = CS_IDLE;
          apply_s     = 1'b1;
        end else begin
          state_nxt_s = CS_PENDING;
        end
      end
      default: state_nxt_s = CS_IDLE;
    endcase
  end

  // Active bank: all fields copied from pre-edge shadow on the same edge
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      blk_en_act_r  <= '0;
      cic_act_r     <= '0;
      coef_act_r    <= '0;
      cfg_updated_r <= 1'b0;
    end else begin
      cfg_updated_r <= apply_s;
      if (apply_s) begin
        blk_en_act_r <= blk_en_sh_r;
        cic_act_r    <= cic_sh_r;
        coef_act_r   <= coef_sh_r;
      end
    end
  end

  // Saturating count of PSLVERR responses
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)               err_cnt_r <= 8'd0;
    else if (pready_s && err_s) err_cnt_r <= sat_inc8(err_cnt_r);
    else                        err_cnt_r <= err_cnt_r;
  end

  // Readback mux over shadow contents and status
  always_comb begin
    rdata_s = '0;
    case (addr_u_s)
      ADDR_CTRL: begin
        rdata_s[CTRL_BLK_EN_LSB +: CTRL_BLK_EN_W] = blk_en_sh_r;
        rdata_s[CTRL_CIC_LSB +: CTRL_CIC_W]       = cic_sh_r;
      end
      ADDR_COMMIT: rdata_s[0] = (state_r == CS_PENDING);
      ADDR_STATUS: begin
        rdata_s[15:8] = err_cnt_r;
        rdata_s[0]    = (state_r == CS_PENDING);
      end
      ADDR_ID: rdata_s = DATA_WIDTH'(ID_VALUE);
      default: rdata_s = coef_rd_s;
    endcase
  end

  assign PREADY         = pready_s;
  assign PSLVERR        = pready_s & err_s;
  assign PRDATA         = (rd_stb_s && !err_s) ? rdata_s : '0;
  assign blk_en         = blk_en_act_r;
  assign cic_decim_log2 = cic_act_r;
  assign coef_bus       = coef_act_r;
  assign commit_pending = (state_r == CS_PENDING);
  assign cfg_updated    = cfg_updated_r;

endmodule

// File: tb/tb_dfe_apb_cfg_regs.sv
// Directed self-checking bench: a zero-wait-state instance for map, commit and
// error behaviour, and a two-wait-state instance for PREADY timing.
module tb_dfe_apb_cfg_regs;

  logic         clk = 1'b0;
  logic         PRESETn;
  logic         psel, penable, pwrite, sample_tick;
  logic [3:0]   paddr;
  logic [31:0]  pwdata, prdata;
  logic         pready, pslverr, commit_pending, cfg_updated;
  logic [4:0]   blk_en, cic;
  logic [159:0] coef_bus;

  logic         psel1, penable1, pwrite1, tick1;
  logic [3:0]   paddr1;
  logic [31:0]  pwdata1, prdata1;
  logic         pready1, pslverr1, commit_pending1, cfg_updated1;
  logic [4:0]   blk_en1, cic1;
  logic [159:0] coef_bus1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dfe_apb_cfg_regs #(.WAIT_STATES(0)) dut (
    .PCLK(clk), .PRESETn(PRESETn), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .sample_tick(sample_tick), .blk_en(blk_en), .cic_decim_log2(cic), .coef_bus(coef_bus),
    .commit_pending(commit_pending), .cfg_updated(cfg_updated)
  );

  dfe_apb_cfg_regs #(.WAIT_STATES(2)) dut_ws (
    .PCLK(clk), .PRESETn(PRESETn), .PSEL(psel1), .PENABLE(penable1), .PWRITE(pwrite1),
    .PADDR(paddr1), .PWDATA(pwdata1), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1),
    .sample_tick(tick1), .blk_en(blk_en1), .cic_decim_log2(cic1), .coef_bus(coef_bus1),
    .commit_pending(commit_pending1), .cfg_updated(cfg_updated1)
  );

  task automatic apb(input int which, input logic wr, input logic [3:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output logic err);
    logic ok;
    ok = 1'b0; rd = '0; err = 1'b0;
    @(posedge clk); #1;
    if (which == 0) begin psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; end
    else begin psel1 = 1'b1; penable1 = 1'b0; pwrite1 = wr; paddr1 = a; pwdata1 = d; end
    @(posedge clk); #1;
    if (which == 0) penable = 1'b1;
    else            penable1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if ((which == 0) ? pready : pready1) begin
        ok  = 1'b1;
        rd  = (which == 0) ? prdata : prdata1;
        err = (which == 0) ? pslverr : pslverr1;
        break;
      end
    end
    @(posedge clk); #1;
    if (which == 0) begin psel = 1'b0; penable = 1'b0; end
    else begin psel1 = 1'b0; penable1 = 1'b0; end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL apb_timeout addr=%h got no PREADY, required PREADY=1", a); end
  endtask

  task automatic wr_with_tick(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1; sample_tick = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pready !== 1'b1) begin n_fail++; $display("FAIL wr_tick_ready got=%b exp=1", pready); end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; sample_tick = 1'b0;
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1; sample_tick = 1'b1;
    @(posedge clk); #1; sample_tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err;
    @(negedge clk);
    n_checks++; if (pready !== 1'b0) begin n_fail++; $display("FAIL rst_pready got=%b exp=0", pready); end
    n_checks++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL rst_pslverr got=%b exp=0", pslverr); end
    n_checks++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL rst_prdata got=%h exp=0", prdata); end
    n_checks++; if (blk_en !== 5'h0 || cic !== 5'h0) begin n_fail++; $display("FAIL rst_ctrl got=%h/%h exp=0/0", blk_en, cic); end
    n_checks++; if (coef_bus !== 160'h0) begin n_fail++; $display("FAIL rst_coef got=%h exp=0", coef_bus); end
    n_checks++; if (commit_pending !== 1'b0 || cfg_updated !== 1'b0) begin n_fail++; $display("FAIL rst_commit got=%b%b exp=00", commit_pending, cfg_updated); end
    @(posedge clk); #1; PRESETn = 1'b1;
    // reset asserted during the access phase of a CTRL write
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = 32'h0000_0815;
    @(posedge clk); #1; penable = 1'b1;
    #2; PRESETn = 1'b0;
    @(negedge clk);
    n_checks++; if (pready !== 1'b0 || pslverr !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got=%b%b exp=00", pready, pslverr); end
    n_checks++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL midrst_prdata got=%h exp=0", prdata); end
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1; PRESETn = 1'b1;
    apb(0, 1'b0, 4'h0, 32'h0, rd, err);
    n_checks++; if (rd !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got=%h err=%b exp=0 err=0", rd, err); end
  endtask

  task automatic test_commit();
    logic [31:0] rd; logic err;
    apb(0, 1'b1, 4'h0, 32'h0000_081F, rd, err);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_ctrl_err got=%b exp=0", err); end
    apb(0, 1'b1, 4'h2, 32'h4000_678E, rd, err);
    apb(0, 1'b1, 4'h1, 32'h0000_0001, rd, err);
    apb(0, 1'b0, 4'h0, 32'h0, rd, err);
    n_checks++; if (rd !== 32'h0000_081F) begin n_fail++; $display("FAIL rd_ctrl_shadow got=%h exp=0000081f", rd); end
    apb(0, 1'b0, 4'h2, 32'h0, rd, err);
    n_checks++; if (rd !== 32'h4000_678E) begin n_fail++; $display("FAIL rd_coef0 got=%h exp=4000678e", rd); end
    n_checks++; if (blk_en !== 5'h0 || coef_bus[31:0] !== 32'h0) begin n_fail++; $display("FAIL active_before_tick got=%h/%h exp=0/0", blk_en, coef_bus[31:0]); end
    n_checks++; if (commit_pending !== 1'b1) begin n_fail++; $display("FAIL pending_set got=%b exp=1", commit_pending); end
    apb(0, 1'b0, 4'hE, 32'h0, rd, err);
    n_checks++; if (rd !== 32'h0000_0001) begin n_fail++; $display("FAIL status_pending got=%h exp=00000001", rd); end
    apb(0, 1'b0, 4'h1, 32'h0, rd, err);
    n_checks++; if (rd !== 32'h0000_0001) begin n_fail++; $display("FAIL commit_rd got=%h exp=00000001", rd); end
    apb(0, 1'b0, 4'hF, 32'h0, rd, err);
    n_checks++; if (rd !== 32'hDFE0_0002) begin n_fail++; $display("FAIL id_rd got=%h exp=dfe00002", rd); end
    pulse_tick();
    @(negedge clk);
    n_checks++; if (blk_en !== 5'h1F || cic !== 5'd4) begin n_fail++; $display("FAIL applied_ctrl got=%h/%h exp=1f/4", blk_en, cic); end
    n_checks++; if (coef_bus[31:0] !== 32'h4000_678E) begin n_fail++; $display("FAIL applied_coef0 got=%h exp=4000678e", coef_bus[31:0]); end
    n_checks++; if (cfg_updated !== 1'b1 || commit_pending !== 1'b0) begin n_fail++; $display("FAIL applied_flags got=%b%b exp=10", cfg_updated, commit_pending); end
    @(negedge clk);
    n_checks++; if (cfg_updated !== 1'b0) begin n_fail++; $display("FAIL cfg_updated_pulse got=%b exp=0", cfg_updated); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err;
    apb(0, 1'b1, 4'h0, 32'h0000_0A00, rd, err);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_cic_range got=%b exp=1", err); end
    apb(0, 1'b1, 4'hF, 32'h1234_5678, rd, err);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_wr_id got=%b exp=1", err); end
    apb(0, 1'b0, 4'h9, 32'h0, rd, err);
    n_checks++; if (err !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_unmapped got=%b rd=%h exp=1 rd=0", err, rd); end
    apb(0, 1'b0, 4'h0, 32'h0, rd, err);
    n_checks++; if (rd !== 32'h0000_081F || err !== 1'b0) begin n_fail++; $display("FAIL ctrl_unchanged got=%h exp=0000081f", rd); end
    apb(0, 1'b0, 4'hE, 32'h0, rd, err);
    n_checks++; if (rd !== 32'h0000_0300) begin n_fail++; $display("FAIL status_errcnt got=%h exp=00000300", rd); end
  endtask

  task automatic test_coincident();
    logic [31:0] rd; logic err;
    int pulses;
    apb(0, 1'b1, 4'h0, 32'h0000_0403, rd, err);
    wr_with_tick(4'h1, 32'h0000_0001);
    @(negedge clk);
    n_checks++; if (commit_pending !== 1'b1 || cfg_updated !== 1'b0) begin n_fail++; $display("FAIL commit_on_tick got=%b%b exp=10", commit_pending, cfg_updated); end
    n_checks++; if (blk_en !== 5'h1F) begin n_fail++; $display("FAIL commit_on_tick_blk got=%h exp=1f", blk_en); end
    wr_with_tick(4'h0, 32'h0000_0011);
    @(negedge clk);
    n_checks++; if (blk_en !== 5'h03 || cic !== 5'd2) begin n_fail++; $display("FAIL apply_prewrite got=%h/%h exp=03/2", blk_en, cic); end
    n_checks++; if (cfg_updated !== 1'b1 || commit_pending !== 1'b0) begin n_fail++; $display("FAIL apply_prewrite_flags got=%b%b exp=10", cfg_updated, commit_pending); end
    apb(0, 1'b0, 4'h0, 32'h0, rd, err);
    n_checks++; if (rd !== 32'h0000_0011) begin n_fail++; $display("FAIL shadow_after_apply got=%h exp=00000011", rd); end
    apb(0, 1'b1, 4'h1, 32'h0000_0001, rd, err);
    apb(0, 1'b1, 4'h1, 32'h0000_0001, rd, err);
    n_checks++; if (commit_pending !== 1'b1) begin n_fail++; $display("FAIL double_commit_pending got=%b exp=1", commit_pending); end
    pulse_tick();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cfg_updated === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL single_apply got=%0d pulses exp=1", pulses); end
    n_checks++; if (blk_en !== 5'h11 || cic !== 5'd0) begin n_fail++; $display("FAIL second_apply got=%h/%h exp=11/0", blk_en, cic); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err;
    @(posedge clk); #1;
    psel1 = 1'b1; penable1 = 1'b0; pwrite1 = 1'b1; paddr1 = 4'h0; pwdata1 = 32'h0000_0005;
    @(posedge clk); #1; penable1 = 1'b1;
    @(negedge clk);
    n_checks++; if (pready1 !== 1'b0) begin n_fail++; $display("FAIL ws_access1 got=%b exp=0", pready1); end
    @(negedge clk);
    n_checks++; if (pready1 !== 1'b0) begin n_fail++; $display("FAIL ws_access2 got=%b exp=0", pready1); end
    @(negedge clk);
    n_checks++; if (pready1 !== 1'b1 || pslverr1 !== 1'b0) begin n_fail++; $display("FAIL ws_access3 got=%b%b exp=10", pready1, pslverr1); end
    @(posedge clk); #1; psel1 = 1'b0; penable1 = 1'b0;
    // abandoned transfer: PSEL dropped after one access cycle
    @(posedge clk); #1;
    psel1 = 1'b1; penable1 = 1'b0; pwrite1 = 1'b1; paddr1 = 4'h0; pwdata1 = 32'h0000_001F;
    @(posedge clk); #1; penable1 = 1'b1;
    @(negedge clk);
    n_checks++; if (pready1 !== 1'b0) begin n_fail++; $display("FAIL ws_abandon_ready got=%b exp=0", pready1); end
    @(posedge clk); #1; psel1 = 1'b0; penable1 = 1'b0;
    apb(1, 1'b0, 4'h0, 32'h0, rd, err);
    n_checks++; if (rd !== 32'h0000_0005 || err !== 1'b0) begin n_fail++; $display("FAIL ws_abandon_nowrite got=%h exp=00000005", rd); end
    n_checks++; if (blk_en1 !== 5'h0) begin n_fail++; $display("FAIL ws_active got=%h exp=0", blk_en1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    PRESETn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0; pwdata = 32'h0;
    sample_tick = 1'b0;
    psel1 = 1'b0; penable1 = 1'b0; pwrite1 = 1'b0; paddr1 = 4'h0; pwdata1 = 32'h0; tick1 = 1'b0;
    test_reset();
    test_commit();
    test_errors();
    test_coincident();
    test_wait_states();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
